mem_access_stage: RTL and testbench

Memory-stage data access unit of the pipelined MIPS core. Sits directly downstream of the EX/MEM pipeline register and consumes its M-stage outputs: address, store data, width, load/store controls and incoming exception vector. It runs one SRAM-like bus transaction per load/store, holds the pipeline with a stall until the access completes, and delivers aligned, extended load data plus an updated exception vector to the MEM/WB register.

---
 rtl/mem_access_stage.sv | 128 ++++++++++++
 tb/tb_mem_access_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: one SRAM-like bus transaction per access, with a pipeline stall and load alignment/extension.
// Optional macro ADDR_EXC_EN enables the alignment check that raises AdEL (bit 4) and AdES (bit 5).
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemToRegM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemWidthM,
  input  logic        LoadUnsignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] PhyAddrM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ExceptionTypeM,
  input  logic        AdvanceM,
  input  logic        FlushM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic [31:0] ExceptionTypeOutM,
  output logic [31:0] BadVAddrOutM
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic        access_needed;
  logic        load_unsigned_reg;
  logic [1:0]  size_in;
  logic [31:0] store_lanes;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

`ifdef ADDR_EXC_EN
  logic misaligned, adel, ades;
  assign misaligned = (MemWidthM == 2'b01) ? ALUOutM[0]
                    : (MemWidthM[1] ? (ALUOutM[1:0] != 2'b00) : 1'b0);
  assign adel = MemToRegM & misaligned;
  assign ades = MemWriteM & misaligned;
  assign ExceptionTypeOutM = ExceptionTypeM | {26'd0, ades, adel, 4'd0};
  assign BadVAddrOutM      = (adel | ades) ? ALUOutM : 32'd0;
`else
  logic unused_vaddr;
  assign unused_vaddr      = ^ALUOutM;
  assign ExceptionTypeOutM = ExceptionTypeM;
  assign BadVAddrOutM      = 32'd0;
`endif

  assign access_needed = (MemToRegM | MemWriteM) & (ExceptionTypeOutM == 32'd0);
  assign size_in       = (MemWidthM == 2'b11) ? 2'b10 : MemWidthM;

  // Each byte lane picks the store byte that lands on it for the given width.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign store_lanes[gi*8 +: 8] =
          (size_in == 2'b00) ? WriteDataM[7:0] :
          (size_in == 2'b01) ? WriteDataM[(gi % 2)*8 +: 8] :
                               WriteDataM[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    ld_byte  = data_rdata[{data_addr[1:0], 3'b000} +: 8];
    ld_half  = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    ld_value = data_rdata;
    if (data_size == 2'b00)
      ld_value = load_unsigned_reg ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    else if (data_size == 2'b01)
      ld_value = load_unsigned_reg ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      // A flushed instruction must never start a bus access (a store would be irreversible).
      IDLE:  if (access_needed && !FlushM) state_next = REQ;
      REQ: begin
        if (data_addr_ok) begin
          if (data_data_ok) state_next = FlushM ? IDLE : DONE;
          else              state_next = FlushM ? DRAIN : WAIT;
        end else if (FlushM) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (FlushM)            state_next = data_data_ok ? IDLE : DRAIN;
        else if (data_data_ok) state_next = DONE;
      end
      DRAIN: if (data_data_ok) state_next = IDLE;
      DONE:  if (AdvanceM || FlushM) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      data_wr           <= 1'b0;
      data_size         <= 2'b00;
      data_addr         <= 32'd0;
      data_wdata        <= 32'd0;
      load_unsigned_reg <= 1'b0;
      ReadDataM         <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && state_next == REQ) begin
        data_wr           <= MemWriteM;
        data_size         <= size_in;
        data_addr         <= PhyAddrM;
        data_wdata        <= store_lanes;
        load_unsigned_reg <= LoadUnsignedM;
      end
      if (state_next == DONE && state_reg != DONE && !data_wr)
        ReadDataM <= ld_value;
    end
  end

  assign data_req = (state_reg == REQ);
  assign StallM   = (access_needed && state_reg != DONE) || (state_reg == DRAIN);

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: handshake timing, lane handling, flush/drain and reset abort.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemToRegM, MemWriteM, LoadUnsignedM, AdvanceM, FlushM;
  logic [1:0]  MemWidthM;
  logic [31:0] ALUOutM, PhyAddrM, WriteDataM, ExceptionTypeM;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [31:0] ReadDataM, ExceptionTypeOutM, BadVAddrOutM;
  logic        StallM;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .MemWidthM(MemWidthM),
    .LoadUnsignedM(LoadUnsignedM), .ALUOutM(ALUOutM), .PhyAddrM(PhyAddrM),
    .WriteDataM(WriteDataM), .ExceptionTypeM(ExceptionTypeM),
    .AdvanceM(AdvanceM), .FlushM(FlushM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ReadDataM(ReadDataM), .StallM(StallM),
    .ExceptionTypeOutM(ExceptionTypeOutM), .BadVAddrOutM(BadVAddrOutM)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_instr();
    MemToRegM = 0; MemWriteM = 0; MemWidthM = 2'b00; LoadUnsignedM = 0;
    ALUOutM = 0; PhyAddrM = 0; WriteDataM = 0; ExceptionTypeM = 0;
    AdvanceM = 0; FlushM = 0;
  endtask

  task automatic present(input logic wr, input logic [1:0] w, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    MemToRegM = ~wr; MemWriteM = wr; MemWidthM = w; LoadUnsignedM = uns;
    ALUOutM = addr; PhyAddrM = addr; WriteDataM = wd;
  endtask

  // Zero-wait access: addr_ok and data_ok together on the first REQ cycle.
  task automatic do_access(input string tag, input logic wr, input logic [1:0] w,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input logic [1:0] exp_size,
                           input logic [31:0] exp_val);
    tick();
    present(wr, w, uns, addr, wd);
    data_addr_ok = 1; data_data_ok = 1; data_rdata = rd;
    #1;
    check({tag, "_c0_stall"}, StallM, 1);
    check({tag, "_c0_req"}, data_req, 0);
    tick();
    check({tag, "_c1_req"}, data_req, 1);
    check({tag, "_c1_stall"}, StallM, 1);
    check({tag, "_wr"}, data_wr, wr);
    check({tag, "_size"}, data_size, exp_size);
    check({tag, "_addr"}, data_addr, addr);
    if (wr) check({tag, "_wdata"}, data_wdata, exp_val);
    tick();
    data_addr_ok = 0; data_data_ok = 0;
    #1;
    check({tag, "_c2_req"}, data_req, 0);
    check({tag, "_c2_stall"}, StallM, 0);
    if (!wr) last_rd = exp_val;
    check({tag, "_rdata"}, ReadDataM, last_rd);
    $display("txn %s wr=%0d addr=%08h size=%0d rd=%08h", tag, wr, addr, data_size, ReadDataM);
    AdvanceM = 1;
    tick();
    clear_instr();
  endtask

  initial begin
    rst = 0; clear_instr();
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    last_rd = 0;
    #3;
    check("rst_req", data_req, 0);
    check("rst_wr", data_wr, 0);
    check("rst_size", data_size, 0);
    check("rst_addr", data_addr, 0);
    check("rst_wdata", data_wdata, 0);
    check("rst_rdata", ReadDataM, 0);
    check("rst_stall", StallM, 0);
    tick();
    rst = 1;

    do_access("lb",  0, 2'b00, 0, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 2'b00, 32'hFFFF_FF80);
    do_access("lbu", 0, 2'b00, 1, 32'h0000_1001, 32'h0, 32'h0000_A500, 2'b00, 32'h0000_00A5);
    do_access("lh",  0, 2'b01, 0, 32'h0000_1000, 32'h0, 32'h1234_8001, 2'b01, 32'hFFFF_8001);
    do_access("lw11",0, 2'b11, 0, 32'h0000_1004, 32'h0, 32'hCAFE_F00D, 2'b10, 32'hCAFE_F00D);
    do_access("sb",  1, 2'b00, 0, 32'h0000_2001, 32'h0000_00AB, 32'h0, 2'b00, 32'hABAB_ABAB);
    do_access("sh",  1, 2'b01, 0, 32'h0000_2002, 32'hFFFF_1234, 32'h0, 2'b01, 32'h1234_1234);
    do_access("sw",  1, 2'b10, 0, 32'h0000_2004, 32'h89AB_CDEF, 32'h0, 2'b10, 32'h89AB_CDEF);

    // lhu with data_ok three cycles after addr_ok
    tick();
    present(0, 2'b01, 1, 32'h0000_1002, 32'h0);
    #1;
    check("lhu_c0_stall", StallM, 1);
    tick();
    data_addr_ok = 1;
    #1;
    check("lhu_c1_req", data_req, 1);
    check("lhu_c1_stall", StallM, 1);
    for (int i = 2; i <= 3; i++) begin
      tick();
      data_addr_ok = 0;
      #1;
      check($sformatf("lhu_c%0d_stall", i), StallM, 1);
      check($sformatf("lhu_c%0d_req", i), data_req, 0);
    end
    tick();
    data_data_ok = 1; data_rdata = 32'hBEEF_0000;
    #1;
    check("lhu_c4_stall", StallM, 1);
    tick();
    data_data_ok = 0; data_rdata = 32'h0;
    #1;
    last_rd = 32'h0000_BEEF;
    check("lhu_c5_stall", StallM, 0);
    check("lhu_rdata", ReadDataM, last_rd);
    tick();
    check("lhu_hold_rdata", ReadDataM, last_rd);
    check("lhu_hold_stall", StallM, 0);
    $display("txn lhu addr=%08h rd=%08h", data_addr, ReadDataM);
    AdvanceM = 1;
    tick();
    clear_instr();

`ifdef ADDR_EXC_EN
    tick();
    present(0, 2'b10, 0, 32'h0000_0102, 32'h0);
    #1;
    check("adel_exc", ExceptionTypeOutM, 32'h0000_0010);
    check("adel_bad", BadVAddrOutM, 32'h0000_0102);
    check("adel_stall", StallM, 0);
    tick();
    check("adel_req", data_req, 0);
    present(1, 2'b01, 0, 32'h0000_2003, 32'h0);
    #1;
    check("ades_exc", ExceptionTypeOutM, 32'h0000_0020);
    check("ades_bad", BadVAddrOutM, 32'h0000_2003);
    tick();
    check("ades_req", data_req, 0);
    $display("txn misaligned lw/sh trapped");
    clear_instr();
`else
    do_access("lwmis", 0, 2'b10, 0, 32'h0000_0102, 32'h0, 32'h1122_3344, 2'b10, 32'h1122_3344);
    check("lwmis_bad", BadVAddrOutM, 0);
`endif

    // Incoming exception suppresses the access
    tick();
    present(0, 2'b10, 0, 32'h0000_1008, 32'h0);
    ExceptionTypeM = 32'h0000_0100;
    #1;
    check("exc_stall", StallM, 0);
    check("exc_out", ExceptionTypeOutM, 32'h0000_0100);
    check("exc_bad", BadVAddrOutM, 0);
    tick();
    check("exc_req", data_req, 0);
    $display("txn suppressed lw exc=%08h", ExceptionTypeOutM);
    clear_instr();

    // Flush in WAIT, data_ok arrives two cycles later
    tick();
    present(0, 2'b10, 0, 32'h0000_3000, 32'h0);
    #1;
    tick();
    data_addr_ok = 1;
    #1;
    check("fl_c1_req", data_req, 1);
    tick();
    data_addr_ok = 0; FlushM = 1;
    #1;
    check("fl_c2_stall", StallM, 1);
    tick();
    clear_instr();
    #1;
    check("fl_c3_stall", StallM, 1);
    check("fl_c3_req", data_req, 0);
    tick();
    data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    #1;
    check("fl_c4_stall", StallM, 1);
    tick();
    data_data_ok = 0;
    #1;
    check("fl_c5_stall", StallM, 0);
    check("fl_c5_req", data_req, 0);
    check("fl_rdata", ReadDataM, last_rd);
    $display("txn flush-drain rd=%08h", ReadDataM);

    // Flush and data_ok in the same WAIT cycle
    tick();
    present(0, 2'b10, 0, 32'h0000_3004, 32'h0);
    #1;
    tick();
    data_addr_ok = 1;
    #1;
    tick();
    data_addr_ok = 0; FlushM = 1; data_data_ok = 1; data_rdata = 32'h5555_5555;
    #1;
    tick();
    clear_instr(); data_data_ok = 0;
    #1;
    check("flok_stall", StallM, 0);
    check("flok_req", data_req, 0);
    check("flok_rdata", ReadDataM, last_rd);
    $display("txn flush+data_ok rd=%08h", ReadDataM);

    // Reset asserted while in REQ
    tick();
    present(0, 2'b10, 0, 32'h0000_4000, 32'h0);
    #1;
    tick();
    check("rr_req_pre", data_req, 1);
    #2;
    rst = 0;
    #1;
    check("rr_req", data_req, 0);
    check("rr_addr", data_addr, 0);
    check("rr_rdata", ReadDataM, 0);
    clear_instr();
    tick();
    rst = 1; data_addr_ok = 1; data_data_ok = 1; data_rdata = 32'h7777_7777;
    #1;
    check("rr_late_stall", StallM, 0);
    tick();
    data_addr_ok = 0; data_data_ok = 0;
    #1;
    check("rr_late_req", data_req, 0);
    check("rr_late_rdata", ReadDataM, 0);
    check("rr_late_stall2", StallM, 0);
    $display("txn reset-abort rd=%08h", ReadDataM);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
